bram_arbiter: RTL

- Shares one single-bit simple-dual-port BRAM (sdp_bram) between two requesters.
- Sits between the puzzle-solver engines and the top-level BRAM instance.
- On reset, and on request, it sequences a full-memory clear.
- It then round-robin arbitrates the read port and the write port independently, returning read data tagged with the requester id.

---
 rtl/bram_arbiter_pkg.sv | 13 +
 rtl/bram_arbiter_rr_arb2.sv | 35 +++
 rtl/bram_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the BRAM arbiter: controller states, requester count
// and requester id width.
package bram_arb_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grants the preferred requester if valid, else the
// other; after a grant the preference moves to the requester that lost.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr;

    always_comb begin
        grant = '0;
        if (grant_en) begin
            if (valid[ptr]) begin
                grant[ptr] = 1'b1;
            end else if (valid[~ptr]) begin
                grant[~ptr] = 1'b1;
            end
        end
    end

    // Granting requester 0 makes requester 1 preferred, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-bit simple-dual-port BRAM between two requesters: clears the
// memory after reset or on request, then round-robin arbitrates reads and writes.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  clear_done,
    input  logic [1:0]            rd_valid,
    input  logic [2*ADDR_W-1:0]   rd_addr,
    output logic [1:0]            rd_ready,
    output logic                  rd_rsp_valid,
    output logic                  rd_rsp_id,
    output logic                  rd_rsp_data,
    input  logic [1:0]            wr_valid,
    input  logic [2*ADDR_W-1:0]   wr_addr,
    input  logic [1:0]            wr_data,
    output logic [1:0]            wr_ready,
    output logic [ADDR_W-1:0]     bram_read_addr,
    output logic [ADDR_W-1:0]     bram_write_addr,
    output logic                  bram_write_val,
    output logic                  bram_write_en,
    input  logic                  bram_read_val
);

    state_t              state;
    logic [ADDR_W-1:0]   clear_cnt;
    logic                grant_en;
    logic [NUM_REQ-1:0]  wr_grant;
    logic [NUM_REQ-1:0]  rd_grant;
    logic [NUM_REQ-1:0]  rd_elig;
    logic                wr_fire;
    logic                rd_fire;
    logic [ID_W-1:0]     wr_sel;
    logic [ID_W-1:0]     rd_sel;
    logic [ADDR_W-1:0]   wr_sel_addr;
    logic [ADDR_W-1:0]   rd_sel_addr;
    logic                pipe_valid;
    logic [ID_W-1:0]     pipe_id;

    assign grant_en   = (state == ST_RUN) && !clear_req;
    assign clear_done = (state == ST_RUN);

    rr_arb2 u_wr_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    (wr_valid),
        .grant_en (grant_en),
        .grant    (wr_grant)
    );

    assign wr_fire     = |wr_grant;
    assign wr_sel      = wr_grant[1];
    assign wr_sel_addr = wr_sel ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];

    // A read colliding with this cycle's granted write would see pre-write data,
    // so it is held back one cycle.
    always_comb begin
        rd_elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rd_elig[i] = rd_valid[i] &&
                         !(wr_fire && (rd_addr[i*ADDR_W +: ADDR_W] == wr_sel_addr));
        end
    end

    rr_arb2 u_rd_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    (rd_elig),
        .grant_en (grant_en),
        .grant    (rd_grant)
    );

    assign rd_fire     = |rd_grant;
    assign rd_sel      = rd_grant[1];
    assign rd_sel_addr = rd_sel ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];

    assign rd_ready    = rd_grant;
    assign wr_ready    = wr_grant;
    assign rd_rsp_data = rd_rsp_valid & bram_read_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_CLEAR;
            clear_cnt       <= '0;
            bram_write_en   <= 1'b0;
            bram_write_addr <= '0;
            bram_write_val  <= 1'b0;
            bram_read_addr  <= '0;
            pipe_valid      <= 1'b0;
            pipe_id         <= '0;
            rd_rsp_valid    <= 1'b0;
            rd_rsp_id       <= 1'b0;
        end else begin
            // Read pipeline runs in every state so in-flight reads finish during a clear.
            pipe_valid   <= rd_fire;
            rd_rsp_valid <= pipe_valid;
            rd_rsp_id    <= pipe_id;
            if (rd_fire) begin
                pipe_id        <= rd_sel;
                bram_read_addr <= rd_sel_addr;
            end

            case (state)
                ST_CLEAR: begin
                    bram_write_en   <= 1'b1;
                    bram_write_val  <= 1'b0;
                    bram_write_addr <= clear_cnt;
                    clear_cnt       <= clear_cnt + ADDR_W'(1);
                    if (clear_cnt == '1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    bram_write_en <= wr_fire;
                    if (wr_fire) begin
                        bram_write_addr <= wr_sel_addr;
                        bram_write_val  <= wr_data[wr_sel];
                    end
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        clear_cnt <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule
